// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit holding the HI/LO registers.
// Multiplies use radix-2 shift-add and divides use restoring shift-subtract,
// one iteration per clock for 32 clocks, then a single sign-fix cycle.
module mult_div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] bus_a,
    input  logic [31:0] bus_b,
    input  logic        mthi,
    input  logic        mtlo,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    // Latched operation context.
    logic [4:0]  count;
    logic        is_div;
    logic        neg_main;    // negate product or quotient in FIX
    logic        neg_rem;     // negate remainder in FIX (dividend sign)
    logic        div_zero;
    logic [31:0] opb;         // multiplicand addend or divisor magnitude

    // Working pair: {acc_hi, acc_lo} is the product shift register for
    // multiply, or {remainder, dividend/quotient} for divide.
    logic [31:0] acc_hi;
    logic [31:0] acc_lo;

    // Operand preparation at latch time.
    logic        signed_op;
    logic        sign_a;
    logic        sign_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;

    // One iteration step.
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic [32:0] div_diff;
    logic [31:0] step_hi;
    logic [31:0] step_lo;

    // Final sign-corrected result.
    logic [63:0] prod_fixed;
    logic [31:0] quot_fixed;
    logic [31:0] rem_fixed;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    assign busy = (state != IDLE);

    // Magnitudes and signs of the incoming operands; unsigned ops see no sign.
    always_comb begin
        // NOTE: every always_comb output gets a value on every path, otherwise
        // synthesis infers a latch to remember the old value.
        signed_op = ~op[0];
        sign_a    = signed_op & bus_a[31];
        sign_b    = signed_op & bus_b[31];
        mag_a     = sign_a ? (~bus_a + 32'd1) : bus_a;
        mag_b     = sign_b ? (~bus_b + 32'd1) : bus_b;
    end

    // One radix-2 iteration for either multiply or divide.
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : 33'd0);
        // The partial remainder is always below the divisor, so the shifted
        // value is below twice the divisor and the 33-bit difference cannot
        // overflow its sign bit.
        div_shift = {acc_hi, acc_lo[31]};
        div_diff  = div_shift - {1'b0, opb};
        step_hi   = acc_hi;
        step_lo   = acc_lo;
        if (is_div) begin
            step_hi = div_diff[32] ? div_shift[31:0] : div_diff[31:0];
            step_lo = {acc_lo[30:0], ~div_diff[32]};
        end else begin
            step_hi = mul_sum[32:1];
            step_lo = {mul_sum[0], acc_lo[31:1]};
        end
    end

    // Sign correction and divide-by-zero override applied in FIX.
    always_comb begin
        prod_fixed = neg_main ? (~{acc_hi, acc_lo} + 64'd1) : {acc_hi, acc_lo};
        quot_fixed = neg_main ? (~acc_lo + 32'd1) : acc_lo;
        rem_fixed  = neg_rem  ? (~acc_hi + 32'd1) : acc_hi;
        res_hi     = prod_fixed[63:32];
        res_lo     = prod_fixed[31:0];
        if (is_div) begin
            res_hi = rem_fixed;
            res_lo = div_zero ? 32'hFFFF_FFFF : quot_fixed;
        end
    end

    // Next-state logic: IDLE -> CALC on start, 32 iterations, then one FIX cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (count == 5'd31) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Operand latch, iteration datapath, HI/LO writes and the done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= 5'd0;
            is_div   <= 1'b0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            opb      <= 32'd0;
            acc_hi   <= 32'd0;
            acc_lo   <= 32'd0;
            hi       <= 32'd0;
            lo       <= 32'd0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        // Start wins over any simultaneous MTHI/MTLO.
                        count    <= 5'd0;
                        is_div   <= op[1];
                        neg_main <= sign_a ^ sign_b;
                        neg_rem  <= sign_a;
                        div_zero <= (bus_b == 32'd0);
                        opb      <= mag_b;
                        acc_hi   <= 32'd0;
                        acc_lo   <= mag_a;
                    end else begin
                        if (mthi) hi <= bus_a;
                        if (mtlo) lo <= bus_a;
                    end
                end
                CALC: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    count  <= count + 5'd1;
                end
                FIX: begin
                    hi   <= res_hi;
                    lo   <= res_lo;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases followed by
// random operations compared against an arithmetic reference model.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] bus_a;
    logic [31:0] bus_b;
    logic        mthi;
    logic        mtlo;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks_total  = 0;
    int checks_passed = 0;
    int checks_failed = 0;
    int done_seen     = 0;

    // Expected architectural HI/LO contents.
    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;

    always #5 clk = ~clk;

    // Count done pulses as seen at each rising edge.
    always @(posedge clk) if (done === 1'b1) done_seen <= done_seen + 1;

    mult_div_unit dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .bus_a (bus_a),
        .bus_b (bus_b),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks_total++;
        assert (obs === expv) checks_passed++;
        else begin
            checks_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Reference result {HI, LO} from plain wide arithmetic.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (o)
            2'b00: return 64'(sa * sb);
            2'b01: return ua * ub;
            2'b10: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // One full operation with cycle-exact checks; optionally MT requests with
    // Start, and a Start+MTLO poke before edge poke_edge while busy.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input bit with_mt, input int poke_edge);
        logic [63:0] expv;
        int          seen0;
        expv = model(o, a, b);
        @(negedge clk);
        start = 1'b1; op = o; bus_a = a; bus_b = b; mthi = with_mt; mtlo = with_mt;
        seen0 = done_seen;
        @(negedge clk);                       // past edge 0
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0; bus_a = $urandom; bus_b = $urandom;
        check({tag, " busy_after_start"}, 64'(busy), 64'd1);
        for (int e = 1; e <= 32; e++) begin
            if (e == poke_edge) begin
                start = 1'b1; mtlo = 1'b1; bus_a = 32'h0000_1234;
            end
            @(negedge clk);
            start = 1'b0; mtlo = 1'b0;
        end
        check({tag, " busy_edge32"}, 64'(busy), 64'd1);
        check({tag, " hold_edge32"}, {hi, lo}, {exp_hi, exp_lo});
        check({tag, " no_done_edge32"}, 64'(done), 64'd0);
        @(negedge clk);                       // past edge 33
        exp_hi = expv[63:32];
        exp_lo = expv[31:0];
        check({tag, " idle_edge33"}, 64'(busy), 64'd0);
        check({tag, " done_edge33"}, 64'(done), 64'd1);
        check({tag, " result"}, {hi, lo}, {exp_hi, exp_lo});
        @(negedge clk);                       // past edge 34
        check({tag, " done_low_edge34"}, 64'(done), 64'd0);
        check({tag, " one_done"}, 64'(done_seen - seen0), 64'd1);
    endtask

    initial begin
        int          seen0;
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        int          sel;

        reset = 1'b1; start = 1'b0; op = 2'b00; bus_a = 32'd0; bus_b = 32'd0;
        mthi = 1'b0; mtlo = 1'b0;
        repeat (2) @(negedge clk);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset hilo", {hi, lo}, 64'd0);
        reset = 1'b0;

        // MTHI and MTLO together write both registers without a done pulse.
        seen0 = done_seen;
        mthi = 1'b1; mtlo = 1'b1; bus_a = 32'hCAFE_F00D;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
        exp_hi = 32'hCAFE_F00D; exp_lo = 32'hCAFE_F00D;
        check("mt both hilo", {hi, lo}, {exp_hi, exp_lo});
        check("mt both done", 64'(done), 64'd0);
        check("mt both busy", 64'(busy), 64'd0);

        // MTHI alone leaves LO alone.
        mthi = 1'b1; bus_a = 32'h1357_9BDF;
        @(negedge clk);
        mthi = 1'b0;
        exp_hi = 32'h1357_9BDF;
        check("mthi only", {hi, lo}, {exp_hi, exp_lo});
        @(negedge clk);
        check("mt no done", 64'(done_seen - seen0), 64'd0);

        run_op("mult -3*5",        2'b00, 32'hFFFF_FFFD, 32'd5,        1'b0, -1);
        run_op("multu max*max",    2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, -1);
        run_op("div -7/2",         2'b10, 32'hFFFF_FFF9, 32'd2,        1'b0, -1);
        run_op("div min/-1",       2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, -1);
        run_op("divu 100/0",       2'b11, 32'd100,       32'd0,        1'b0, -1);
        run_op("div -9/0",         2'b10, 32'hFFFF_FFF7, 32'd0,        1'b0, -1);
        run_op("start beats mt",   2'b01, 32'h0001_0003, 32'h0002_0005, 1'b1, -1);
        run_op("poke while busy",  2'b00, 32'h7654_3210, 32'hF00F_1234, 1'b0, 10);

        // Reset in the middle of a DIV aborts it with no done pulse.
        @(negedge clk);
        start = 1'b1; op = 2'b10; bus_a = 32'd1000; bus_b = 32'd7;
        seen0 = done_seen;
        @(negedge clk);                       // past edge 0
        start = 1'b0;
        repeat (11) @(negedge clk);           // past edge 11
        reset = 1'b1;
        @(negedge clk);                       // past edge 12
        reset = 1'b0;
        exp_hi = 32'd0; exp_lo = 32'd0;
        check("abort busy", 64'(busy), 64'd0);
        check("abort hilo", {hi, lo}, 64'd0);
        check("abort done", 64'(done), 64'd0);
        repeat (30) @(negedge clk);
        check("abort no done", 64'(done_seen - seen0), 64'd0);
        check("abort hilo later", {hi, lo}, 64'd0);
        run_op("div after abort",  2'b10, 32'd1000, 32'd7, 1'b0, -1);

        // Reset has priority over Start and MT writes in the same cycle.
        reset = 1'b1; start = 1'b1; mthi = 1'b1; mtlo = 1'b1; bus_a = 32'hDEAD_BEEF;
        @(negedge clk);
        reset = 1'b0; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        exp_hi = 32'd0; exp_lo = 32'd0;
        check("reset prio busy", 64'(busy), 64'd0);
        check("reset prio hilo", {hi, lo}, 64'd0);

        // Random operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            ro  = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) rb = 32'd0;
            if (sel == 1) rb = $urandom_range(1, 15);
            if (sel == 2) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            if (sel == 3) ra = $urandom_range(0, 255);
            run_op($sformatf("rand%0d op%0d", i, ro), ro, ra, rb, 1'b0, -1);
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
